// File: rtl/shift_pkg.sv
// shift_pkg: shift op encodings and level-to-stage distribution helpers
package shift_pkg;
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;
  function automatic int lvls_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction
  function automatic int stage_first_lvl(input int shamt_w, input int stages, input int k);
    int f;
    f = k * lvls_per_stage(shamt_w, stages);
    return f < shamt_w ? f : shamt_w;
  endfunction
  function automatic int stage_num_lvl(input int shamt_w, input int stages, input int k);
    int f;
    int l;
    f = stage_first_lvl(shamt_w, stages, k);
    l = lvls_per_stage(shamt_w, stages);
    return shamt_w - f < l ? shamt_w - f : l;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: applies this stage's shift levels, then registers the transaction with elastic advance
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dn_adv,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic [1:0]         up_op,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               adv,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] shamt,
  output logic [1:0]         op,
  output logic [TAG_W-1:0]   tag
);
  localparam logic [SHAMT_W-1:0] MASK = SHAMT_W'(((1 << NUM_LVL) - 1) << FIRST_LVL);
  localparam logic [SHAMT_W:0] WN = (SHAMT_W + 1)'(WIDTH);
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] nxt;
  // only this stage's levels contribute; the sum of enabled 2^i levels is the masked amount
  assign amt = up_shamt & MASK;
  assign sra = $signed(up_data) >>> amt;
  assign nxt = up_op == SH_SLL ? up_data << amt :
               up_op == SH_SRL ? up_data >> amt :
               up_op == SH_SRA ? sra :
               (up_data >> amt) | (up_data << (WN - {1'b0, amt}));
  assign adv = !valid || dn_adv;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= up_valid;
      data  <= nxt;
      shamt <= up_shamt;
      op    <= up_op;
      tag   <= up_tag;
    end
  end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: elastic pipelined barrel shifter (SLL/SRL/SRA/ROR) with sideband tag
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES = 2,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);
  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("shift_pipe: WIDTH must be a power of 2 and at least 4");
  end
  if (STAGES < 1 || STAGES > SHAMT_W) begin : g_bad_stages
    $error("shift_pipe: STAGES must be in 1..SHAMT_W");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_pipe: TAG_W must be at least 1");
  end
  logic [STAGES:0] v;
  logic [STAGES:0] adv;
  logic [WIDTH-1:0] d [STAGES+1];
  logic [SHAMT_W-1:0] sh [STAGES+1];
  logic [1:0] op [STAGES+1];
  logic [TAG_W-1:0] tg [STAGES+1];
  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign sh[0] = in_shamt;
  assign op[0] = in_op;
  assign tg[0] = in_tag;
  assign adv[STAGES] = out_ready;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    shift_stage #(
      .WIDTH(WIDTH),
      .TAG_W(TAG_W),
      .FIRST_LVL(stage_first_lvl(SHAMT_W, STAGES, k)),
      .NUM_LVL(stage_num_lvl(SHAMT_W, STAGES, k))
    ) u_stage (
      .clk(clk),
      .reset(reset),
      .dn_adv(adv[k+1]),
      .up_valid(v[k]),
      .up_data(d[k]),
      .up_shamt(sh[k]),
      .up_op(op[k]),
      .up_tag(tg[k]),
      .adv(adv[k]),
      .valid(v[k+1]),
      .data(d[k+1]),
      .shamt(sh[k+1]),
      .op(op[k+1]),
      .tag(tg[k+1])
    );
  end
  // invalid stage contents are don't-care, so the visible outputs are gated to zero
  assign in_ready  = adv[0] && !reset;
  assign out_valid = v[STAGES];
  assign out_data  = v[STAGES] ? d[STAGES] : '0;
  assign out_tag   = v[STAGES] ? tg[STAGES] : '0;
endmodule
